// File: rtl/scope_render.sv
// Oscilloscope trace renderer: ping-pong line store of audio samples drawn over 1080p timing.
// Optional graticule overlay enabled by defining SCOPE_RENDER_GRID_EN.
module scope_render #(
  parameter int          H_ACTIVE  = 1920,
  parameter int          V_ACTIVE  = 1080,
  parameter logic [23:0] FG_COLOUR = 24'h64FFFA,
  parameter logic [23:0] BG_COLOUR = 24'h000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] px_x,
  input  logic [11:0] px_y,
  input  logic        data_en_in,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  input  logic [15:0] smp_data,
  input  logic        smp_valid,
  output logic        smp_ready,
  output logic [23:0] data,
  output logic        h_sync,
  output logic        v_sync,
  output logic        data_en,
  output logic        frame_swap
);

  localparam logic [23:0] GRID_COLOUR = 24'h404040;

  typedef enum logic [0:0] {
    FILL      = 1'b0,
    WAIT_SWAP = 1'b1
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [10:0] r_wr_idx;
  logic [10:0] w_wr_idx_nx;
  logic        r_disp_bank;
  logic        r_shown;
  logic        r_ready;
  logic        r_frame_swap;
  logic        r_vs_prev;
  logic        w_vs_edge;
  logic        w_accept;
  logic        w_swap;
  logic [10:0] w_row;

  logic [10:0] r_bank0 [H_ACTIVE];
  logic [10:0] r_bank1 [H_ACTIVE];

  logic        w_rd_ok;
  logic        r_rd_ok;
  logic [10:0] r_row;
  logic [11:0] r_py_d;
  logic        r_de_d1;
  logic        r_hs_d1;
  logic        r_vs_d1;
  logic signed [12:0] w_diff;
  logic        w_lit;
  logic        w_grid;
  logic [23:0] w_pix;

  logic [23:0] r_data;
  logic        r_hs_d2;
  logic        r_vs_d2;
  logic        r_de_d2;

  assign w_vs_edge = v_sync_in && !r_vs_prev;
  assign w_accept  = smp_valid && r_ready && !rst && (r_state == FILL);
  // Screen row for a sample: centre line 539, one row per 128 LSBs, positive upward.
  assign w_row     = 11'(17'sd539 - ($signed(smp_data) >>> 7));

  always_comb begin
    w_state_nx  = r_state;
    w_wr_idx_nx = r_wr_idx;
    w_swap      = 1'b0;
    case (r_state)
      FILL: begin
        if (w_accept) begin
          if (r_wr_idx == 11'(H_ACTIVE - 1)) begin
            w_wr_idx_nx = 11'd0;
            w_state_nx  = WAIT_SWAP;
          end else begin
            w_wr_idx_nx = 11'(r_wr_idx + 11'd1);
          end
        end
      end
      WAIT_SWAP: begin
        if (w_vs_edge) begin
          w_state_nx = FILL;
          w_swap     = 1'b1;
        end
      end
      default: begin
        w_state_nx  = FILL;
        w_wr_idx_nx = 11'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FILL;
      r_wr_idx     <= 11'd0;
      r_disp_bank  <= 1'b0;
      r_shown      <= 1'b0;
      r_ready      <= 1'b0;
      r_frame_swap <= 1'b0;
      r_vs_prev    <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_wr_idx     <= w_wr_idx_nx;
      r_ready      <= (w_state_nx == FILL);
      r_frame_swap <= w_swap;
      r_vs_prev    <= v_sync_in;
      if (w_swap) begin
        r_disp_bank <= ~r_disp_bank;
        r_shown     <= 1'b1;
      end
    end
  end

  // Line store is not reset; r_shown masks stale contents. Write bank is always ~display bank.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      if (r_disp_bank) r_bank0[r_wr_idx] <= w_row;
      else             r_bank1[r_wr_idx] <= w_row;
    end
  end

  assign w_rd_ok = data_en_in && (px_x < 12'(H_ACTIVE)) && (px_y < 12'(V_ACTIVE));

  always_ff @(posedge clk) begin
    if (w_rd_ok) begin
      r_row <= r_disp_bank ? r_bank1[px_x[10:0]] : r_bank0[px_x[10:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_ok <= 1'b0;
      r_py_d  <= 12'd0;
      r_de_d1 <= 1'b0;
      r_hs_d1 <= 1'b0;
      r_vs_d1 <= 1'b0;
    end else begin
      r_rd_ok <= w_rd_ok;
      r_py_d  <= px_y;
      r_de_d1 <= data_en_in;
      r_hs_d1 <= h_sync_in;
      r_vs_d1 <= v_sync_in;
    end
  end

  assign w_diff = $signed({1'b0, r_py_d}) - $signed({2'b00, r_row});
  assign w_lit  = r_shown && r_rd_ok && (w_diff >= -13'sd1) && (w_diff <= 13'sd1);

`ifdef SCOPE_RENDER_GRID_EN
  logic [11:0] r_px_x_d;

  always_ff @(posedge clk) begin
    if (rst) r_px_x_d <= 12'd0;
    else     r_px_x_d <= px_x;
  end

  assign w_grid = r_rd_ok && ((r_py_d == 12'd539) || ((r_px_x_d % 12'd240) == 12'd0));
`else
  assign w_grid = 1'b0;
`endif

  always_comb begin
    w_pix = 24'h000000;
    if (!r_de_d1)    w_pix = 24'h000000;
    else if (w_lit)  w_pix = FG_COLOUR;
    else if (w_grid) w_pix = GRID_COLOUR;
    else             w_pix = BG_COLOUR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= 24'h000000;
      r_hs_d2 <= 1'b0;
      r_vs_d2 <= 1'b0;
      r_de_d2 <= 1'b0;
    end else begin
      r_data  <= w_pix;
      r_hs_d2 <= r_hs_d1;
      r_vs_d2 <= r_vs_d1;
      r_de_d2 <= r_de_d1;
    end
  end

  assign smp_ready  = r_ready;
  assign frame_swap = r_frame_swap;
  assign data       = r_data;
  assign h_sync     = r_hs_d2;
  assign v_sync     = r_vs_d2;
  assign data_en    = r_de_d2;

endmodule

// File: tb/tb_scope_render.sv
// Directed bench for scope_render: pixel probe tables per image plus hand-written swap/reset sequences.
module tb_scope_render;

  localparam logic [23:0] FG = 24'h64FFFA;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] px_x, px_y;
  logic        data_en_in, h_sync_in, v_sync_in;
  logic [15:0] smp_data;
  logic        smp_valid;
  logic        smp_ready;
  logic [23:0] data;
  logic        h_sync, v_sync, data_en, frame_swap;

  int n_pass   = 0;
  int n_total  = 0;
  int swap_cnt = 0;

  always #5 clk = ~clk;

  scope_render dut (
    .clk(clk), .rst(rst), .px_x(px_x), .px_y(px_y),
    .data_en_in(data_en_in), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .data(data), .h_sync(h_sync), .v_sync(v_sync), .data_en(data_en),
    .frame_swap(frame_swap)
  );

  always @(negedge clk) if (frame_swap === 1'b1) swap_cnt++;

  typedef struct {
    int phase;
    int x;
    int y;
    bit de;
    bit lit;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] unlit(input int x, input int y);
`ifdef SCOPE_RENDER_GRID_EN
    if (x < 1920 && (y == 539 || (x % 240) == 0)) return 24'h404040;
`endif
    return 24'h000000;
  endfunction

  task automatic probe(input string name, input int x, input int y, input bit de, input logic [23:0] exp);
    px_x = 12'(x);
    px_y = 12'(y);
    data_en_in = de;
    tick();
    data_en_in = 1'b0;
    tick();
    check(name, {8'h00, data}, {8'h00, exp});
  endtask

  task automatic apply_phase(input int p);
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].phase == p) begin
        logic [23:0] e;
        e = vecs[i].lit ? FG : (vecs[i].de ? unlit(vecs[i].x, vecs[i].y) : 24'h000000);
        probe($sformatf("pix_p%0d_x%0d_y%0d_de%0d", p, vecs[i].x, vecs[i].y, vecs[i].de),
              vecs[i].x, vecs[i].y, vecs[i].de, e);
      end
    end
  endtask

  function automatic logic [15:0] sval(input int i, input int mode);
    if (mode == 0) begin
      if (i == 0) return 16'h7FFF;
      if (i == 1) return 16'h8000;
      return 16'h0000;
    end
    if (mode == 1) return 16'h1000;
    return 16'h0000;
  endfunction

  task automatic fill(input string name, input int n, input int mode);
    int stalls;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      smp_data  = sval(i, mode);
      smp_valid = 1'b1;
      if (smp_ready !== 1'b1) stalls++;
      tick();
    end
    smp_valid = 1'b0;
    check(name, 32'(stalls), 32'd0);
  endtask

  task automatic vs_pulse(input string name, input logic exp_swap);
    v_sync_in = 1'b1;
    tick();
    check({name, "_pulse"}, {31'd0, frame_swap}, {31'd0, exp_swap});
    v_sync_in = 1'b0;
    tick();
    check({name, "_single"}, {31'd0, frame_swap}, 32'd0);
  endtask

  initial begin
    logic [2:0] hist [0:15];
    logic [2:0] cur;

    vecs = '{
      '{0, 5, 539, 1, 0}, '{0, 0, 284, 1, 0}, '{0, 240, 100, 1, 0}, '{0, 1000, 1000, 0, 0},
      '{1, 5, 538, 1, 1}, '{1, 5, 539, 1, 1}, '{1, 5, 540, 1, 1}, '{1, 5, 537, 1, 0},
      '{1, 5, 541, 1, 0}, '{1, 1919, 539, 1, 1}, '{1, 0, 283, 1, 1}, '{1, 0, 284, 1, 1},
      '{1, 0, 285, 1, 1}, '{1, 0, 282, 1, 0}, '{1, 0, 539, 1, 0}, '{1, 0, 795, 1, 0},
      '{1, 1, 794, 1, 1}, '{1, 1, 795, 1, 1}, '{1, 1, 796, 1, 1}, '{1, 1, 797, 1, 0},
      '{1, 1, 284, 1, 0}, '{1, 1920, 539, 1, 0}, '{1, 5, 539, 0, 0}, '{1, 240, 100, 1, 0},
      '{2, 5, 539, 1, 1}, '{2, 5, 507, 1, 0}, '{2, 0, 284, 1, 1},
      '{3, 5, 507, 1, 1}, '{3, 5, 506, 1, 1}, '{3, 5, 508, 1, 1}, '{3, 5, 539, 1, 0},
      '{3, 0, 284, 1, 0}, '{3, 1919, 507, 1, 1},
      '{4, 5, 507, 1, 0}, '{4, 5, 539, 1, 0}, '{4, 240, 100, 1, 0},
      '{5, 5, 539, 1, 1}, '{5, 5, 507, 1, 0}, '{5, 0, 284, 1, 0}
    };

    // Reset with every input active: outputs must stay zero.
    rst = 1'b1;
    px_x = 12'd5; px_y = 12'd539;
    data_en_in = 1'b1; h_sync_in = 1'b1; v_sync_in = 1'b1;
    smp_data = 16'h1234; smp_valid = 1'b1;
    tick(); tick(); tick();
    check("rst_data", {8'h00, data}, 32'd0);
    check("rst_syncs", {29'd0, h_sync, v_sync, data_en}, 32'd0);
    check("rst_ready", {31'd0, smp_ready}, 32'd0);
    check("rst_swap", {31'd0, frame_swap}, 32'd0);
    data_en_in = 1'b0; h_sync_in = 1'b0; v_sync_in = 1'b0; smp_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("ready_before_edge", {31'd0, smp_ready}, 32'd0);
    tick();
    check("ready_after_rst", {31'd0, smp_ready}, 32'd1);

    // Nothing buffered: BG everywhere, v_sync edge while filling gives no swap.
    apply_phase(0);
    vs_pulse("no_fill_vs", 1'b0);
    check("swap_cnt_none", 32'(swap_cnt), 32'd0);

    // Image A: extremes at columns 0/1, centre line elsewhere.
    fill("fill_a_ready", 1920, 0);
    check("ready_low_after_fill", {31'd0, smp_ready}, 32'd0);
    tick(); tick();
    check("ready_low_waiting", {31'd0, smp_ready}, 32'd0);
    vs_pulse("swap_a", 1'b1);
    check("ready_after_swap", {31'd0, smp_ready}, 32'd1);
    apply_phase(1);

    // Sync/enable delay and data gating over a pattern.
    px_x = 12'd5; px_y = 12'd539;
    for (int i = 0; i < 16; i++) begin
      cur = {i[0], i[2] ^ i[0], i[1] | i[3]};
      hist[i] = cur;
      h_sync_in = cur[2]; v_sync_in = cur[1]; data_en_in = cur[0];
      tick();
      if (i >= 1) begin
        check($sformatf("delay_%0d", i), {29'd0, h_sync, v_sync, data_en}, {29'd0, hist[i-1]});
        check($sformatf("gate_%0d", i), {8'h00, data}, {8'h00, (hist[i-1][0] ? FG : 24'h000000)});
      end
    end
    h_sync_in = 1'b0; v_sync_in = 1'b0; data_en_in = 1'b0;
    tick(); tick();
    check("swap_cnt_after_delay", 32'(swap_cnt), 32'd1);

    // Image B whose last sample lands on a v_sync edge: swap deferred one frame.
    fill("fill_b_ready", 1919, 1);
    smp_data = 16'h1000; smp_valid = 1'b1; v_sync_in = 1'b1;
    tick();
    check("edge_last_no_swap", {31'd0, frame_swap}, 32'd0);
    check("edge_last_ready", {31'd0, smp_ready}, 32'd0);
    smp_valid = 1'b0;
    tick();
    check("edge_last_no_swap2", {31'd0, frame_swap}, 32'd0);
    v_sync_in = 1'b0;
    tick();
    apply_phase(2);
    vs_pulse("swap_b", 1'b1);
    apply_phase(3);

    // Reset mid-fill with active inputs.
    fill("partial_ready", 500, 2);
    px_x = 12'd5; px_y = 12'd507; data_en_in = 1'b1; h_sync_in = 1'b1; smp_valid = 1'b1;
    tick();
    rst = 1'b1;
    tick();
    check("midrst_data", {8'h00, data}, 32'd0);
    check("midrst_syncs", {29'd0, h_sync, v_sync, data_en}, 32'd0);
    check("midrst_ready", {31'd0, smp_ready}, 32'd0);
    rst = 1'b0; data_en_in = 1'b0; h_sync_in = 1'b0; smp_valid = 1'b0;
    tick();
    check("midrst_ready_back", {31'd0, smp_ready}, 32'd1);
    apply_phase(4);
    fill("fill_c_ready", 1920, 2);
    apply_phase(4);
    vs_pulse("swap_c", 1'b1);
    apply_phase(5);
    check("swap_cnt_total", 32'(swap_cnt), 32'd3);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/scope_render.md
Name: scope_render

Overview:
- Pixel-source stage directly downstream of the 1080p HDMI timing generator.
- Consumes px_x, px_y, data_en, h_sync and v_sync from the timing generator, plus a stream of signed audio samples.
- Buffers one screen-width of samples in a ping-pong line store and renders them as an oscilloscope trace.
- Emits RGB data with the sync signals and data enable realigned to the render pipeline latency.

Parameters:
- H_ACTIVE, 1920: active pixels per line; also the samples per bank.
- V_ACTIVE, 1080: active lines.
- FG_COLOUR, 24'h64FFFA: trace colour, {R,G,B}.
- BG_COLOUR, 24'h000000: background colour.

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset
- px_x  in  12  active-area column from timing generator
- px_y  in  12  active-area row from timing generator
- data_en_in  in  1  active-area flag from timing generator
- h_sync_in  in  1  hsync from timing generator
- v_sync_in  in  1  vsync from timing generator
- smp_data  in  16  signed audio sample, two's complement
- smp_valid  in  1  sample valid
- smp_ready  out  1  block can accept a sample
- data  out  24  RGB pixel, {R[23:16],G[15:8],B[7:0]}
- h_sync  out  1  h_sync_in delayed by 2 cycles
- v_sync  out  1  v_sync_in delayed by 2 cycles
- data_en  out  1  data_en_in delayed by 2 cycles
- frame_swap  out  1  one-cycle pulse when the banks swap

Behaviour:
- Reset: rst, synchronous, active-high.
  - All outputs are 0 while rst is high; smp_ready is 0.
  - Write index = 0, display bank = 0, write bank = 1, state = FILL, flag shown = 0.
  - Sync/enable delay pipeline is cleared.
  - Reset mid-frame discards buffered samples; nothing is rendered until the next swap.
- Storage: two banks of H_ACTIVE x 11-bit entries.
  - Entry value: row = 539 - (smp_data >>> 7), signed arithmetic; result range 284..795, stored unsigned.
- Write FSM:
  - FILL: smp_ready = 1.
    - A sample is accepted on a cycle with smp_valid && smp_ready; it is written to write-bank[wr_idx], then wr_idx increments.
    - Accepting at wr_idx == H_ACTIVE-1 moves to WAIT_SWAP, sets wr_idx = 0, and drives smp_ready = 0 from the next cycle.
  - WAIT_SWAP: smp_ready = 0; smp_data is ignored.
- Swap: triggered on a v_sync_in rising edge (v_sync_in = 1 with the registered previous value = 0).
  - In WAIT_SWAP: swap banks, set shown = 1, pulse frame_swap high for exactly 1 cycle, return to FILL.
  - In FILL: no swap; the display bank is shown again unchanged. A partial fill continues.
  - If the last sample is accepted in the same cycle as the edge: state is still FILL, so no swap occurs; the swap happens at the following v_sync edge.
- Read pipeline, 2-cycle latency:
  - Stage 1: registers px_y and data_en_in, and performs a synchronous read of display-bank[px_x].
  - Stage 2: lit = shown && (|px_y_d - row| <= 1), giving a 3-pixel-thick trace.
  - data = data_en ? (lit ? FG_COLOUR : BG_COLOUR) : 24'h0.
  - data_en_in with px_x >= H_ACTIVE: read is suppressed and the pixel is BG.
- h_sync, v_sync and data_en pass through two registers so they stay exactly aligned with data.
- Write and read ports are on separate banks, so no read/write collision is possible.

Optional Feature:
- Macro: SCOPE_RENDER_GRID_EN.
- Defined: graticule of colour 24'h404040 drawn where not lit, at two places:
  - rows px_y_d == 539;
  - columns px_x_d % 240 == 0.
  - Trace colour has priority over graticule.
  - Adds a px_x delay register; latency is unchanged at 2.
- Undefined: no graticule; unlit pixels are BG_COLOUR.

Test Plan:
- Reset, then no samples, full frame -> data = 0 in every active pixel; smp_ready = 1 one cycle after rst falls; frame_swap never pulses.
- Stream 1920 samples of 16'h0000, then one v_sync rising edge -> frame_swap is a 1-cycle pulse; next frame shows FG_COLOUR at rows 538..540 in all columns and BG elsewhere; smp_ready is 0 from the cycle after the 1920th accept until the swap.
- Samples +32767 and -32768 at columns 0 and 1 -> rows 284 and 795 are lit (±1) at those columns; no wrap-around.
- Last sample accepted on the same cycle as a v_sync edge -> no frame_swap at that edge; swap at the next edge; the previous image repeats for one frame.
- Drive known timing inputs -> h_sync, v_sync and data_en equal the inputs delayed by exactly 2 clk; data is 0 wherever data_en = 0.
- Assert rst mid-frame and mid-fill -> outputs are 0 next cycle; BG only until the next complete 1920-sample fill and swap; grid visible when SCOPE_RENDER_GRID_EN is defined (pixel (240,100) = 24'h404040).
